pipe_skid_reg: RTL and testbench

- Parametrised, elastic successor to the fixed-field MEM/WB pipeline register.
- Carries an arbitrary packed payload between two pipeline stages using valid/ready handshakes.
- Holds a two-entry buffer (main + skid), so `in_ready` is fully registered and timing paths are cut in both directions.
- Keeps the existing stall/flush semantics: flush (irq) beats stall and zeroes the contents. Intended for MEM/WB, EX/MEM and later stage boundaries.

---
 rtl/pipe_skid_reg.sv | 103 ++++++++++
 tb/tb_pipe_skid_reg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register: main + optional skid entry, valid/ready on both sides, flush beats stall.
// Latency: 1 cycle in_data -> out_data from empty; steady-state throughput 1 per cycle.
// Backpressure: in_ready registered (~skid valid) when SKID_EN=1, else ~out_valid | (out_ready & ~stall).
module pipe_skid_reg #(
    parameter int DATA_W       = 256,
    parameter bit SKID_EN      = 1'b1,
    parameter bit CLR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              rd;
    logic              accept;
    logic              pop;

    assign rd        = out_ready & ~stall;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign occupancy = state_q;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & rd;

    generate
        if (SKID_EN) begin : g_skid
            assign in_ready = (state_q != TWO);
        end else begin : g_single
            assign in_ready = (state_q == EMPTY) | rd;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d = EMPTY;
            if (CLR_ON_FLUSH) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        main_data_d = in_data;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_data_d = in_data;
                    end else if (accept && SKID_EN) begin
                        state_d     = TWO;
                        skid_data_d = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        skid_data_d = '0;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: an 8-bit skid instance and a 256-bit single-entry instance share stimulus,
// each tracked by its own in-order queue model; directed phases add explicit state checks.
module tb_pipe_skid_reg;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iv, ordy, stall, flush;
    logic [255:0] idat;

    logic         ir_a, ov_a;
    logic [7:0]   od_a;
    logic [1:0]   occ_a;
    logic         ir_b, ov_b;
    logic [255:0] od_b;
    logic [1:0]   occ_b;

    int n_cmp = 0;
    int n_err = 0;
    int obs_a = 0;
    int base;

    logic [255:0] qa[$];
    logic [255:0] qb[$];
    logic         rd_m, erdy_a, erdy_b;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(8), .SKID_EN(1'b1), .CLR_ON_FLUSH(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv), .in_ready(ir_a), .in_data(idat[7:0]),
        .out_valid(ov_a), .out_ready(ordy), .out_data(od_a),
        .stall(stall), .flush(flush), .occupancy(occ_a)
    );

    pipe_skid_reg #(.DATA_W(256), .SKID_EN(1'b0), .CLR_ON_FLUSH(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv), .in_ready(ir_b), .in_data(idat),
        .out_valid(ov_b), .out_ready(ordy), .out_data(od_b),
        .stall(stall), .flush(flush), .occupancy(occ_b)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [255:0] d, input logic r,
                       input logic s, input logic f);
        @(negedge clk);
        iv    = v;
        idat  = d;
        ordy  = r;
        stall = s;
        flush = f;
        #2;
    endtask

    // Scoreboard: outputs are checked against the queue heads, then the queues advance
    // by the handshakes that the next rising edge will perform.
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            qa.delete();
            qb.delete();
        end else begin
            rd_m   = ordy & ~stall;
            erdy_a = (qa.size() < 2);
            erdy_b = (qb.size() == 0) || rd_m;
            chk("a_vld", ov_a, qa.size() != 0);
            chk("a_occ", occ_a, qa.size());
            chk("a_rdy", ir_a, erdy_a);
            if (qa.size() != 0) chk("a_dat", od_a, qa[0]);
            chk("b_vld", ov_b, qb.size() != 0);
            chk("b_occ", occ_b, qb.size());
            chk("b_rdy", ir_b, erdy_b);
            if (qb.size() != 0) chk("b_dat", od_b, qb[0]);
            if (ov_a && rd_m) obs_a++;
            if (flush) begin
                qa.delete();
                qb.delete();
            end else begin
                if (qa.size() != 0 && rd_m) qa.delete(0);
                if (iv && erdy_a) qa.push_back({248'd0, idat[7:0]});
                if (qb.size() != 0 && rd_m) qb.delete(0);
                if (iv && erdy_b) qb.push_back(idat);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        iv    = 1'b0;
        ordy  = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        idat  = '0;

        @(negedge clk);
        #2;
        chk("rst_rdy", ir_a, 1'b1);
        chk("rst_vld", ov_a, 1'b0);
        chk("rst_occ", occ_a, 2'd0);
        chk("rst_dat", od_a, 8'h00);
        #1 rst_n = 1'b1;

        // Back-to-back stream with downstream always ready.
        cyc(1'b1, 256'h11, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 256'h22, 1'b1, 1'b0, 1'b0);
        chk("bb_d1", od_a, 8'h11);
        chk("bb_occ1", occ_a, 2'd1);
        cyc(1'b1, 256'h33, 1'b1, 1'b0, 1'b0);
        chk("bb_d2", od_a, 8'h22);
        chk("bb_rdy2", ir_a, 1'b1);
        cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);
        chk("bb_d3", od_a, 8'h33);
        chk("bb_occ3", occ_a, 2'd1);
        cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);
        chk("bb_empty", ov_a, 1'b0);

        // Fill under stall, then release.
        cyc(1'b1, 256'hA1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 256'hB2, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 256'h0, 1'b1, 1'b1, 1'b0);
        chk("st_occ2", occ_a, 2'd2);
        chk("st_rdy0", ir_a, 1'b0);
        chk("st_dA", od_a, 8'hA1);
        cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);
        chk("st_hold", od_a, 8'hA1);
        cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);
        chk("st_dB", od_a, 8'hB2);
        chk("st_rdy1", ir_a, 1'b1);
        cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);
        chk("st_empty", occ_a, 2'd0);

        // Flush while full and stalled, with a payload offered in the same cycle.
        cyc(1'b1, 256'hC3, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 256'hD4, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 256'h44, 1'b1, 1'b1, 1'b1);
        chk("fl_pre_occ", occ_a, 2'd2);
        cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);
        chk("fl_vld", ov_a, 1'b0);
        chk("fl_occ", occ_a, 2'd0);
        chk("fl_dat", od_a, 8'h00);
        chk("fl_rdy", ir_a, 1'b1);
        cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);
        chk("fl_no44", ov_a, 1'b0);

        // Flush coinciding with a pop from a single held entry.
        cyc(1'b1, 256'hE5, 1'b1, 1'b0, 1'b0);
        base = obs_a;
        cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b1);
        chk("fp_vld", ov_a, 1'b1);
        cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);
        chk("fp_occ", occ_a, 2'd0);
        cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);
        chk("fp_once", obs_a - base, 1);

        // Asynchronous reset in the middle of a cycle while full.
        cyc(1'b1, 256'h55, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 256'h66, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 256'h0, 1'b1, 1'b1, 1'b0);
        chk("ar_pre_occ", occ_a, 2'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_vld", ov_a, 1'b0);
        chk("ar_occ", occ_a, 2'd0);
        chk("ar_dat", od_a, 8'h00);
        chk("ar_rdy", ir_a, 1'b1);
        chk("ar_b_vld", ov_b, 1'b0);
        @(negedge clk);
        #3 rst_n = 1'b1;

        // Random traffic; both instances checked by the scoreboard every cycle.
        for (int i = 0; i < 10000; i++) begin
            cyc(($urandom % 4) != 0,
                {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom},
                ($urandom % 3) != 0,
                ($urandom % 8) == 0,
                ($urandom % 64) == 0);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 256'h0, 1'b1, 1'b0, 1'b0);
        chk("drain_a", occ_a, 2'd0);
        chk("drain_b", occ_b, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
